// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state codes, oversampling constants and the baud divisor.
// Used by uart_rx (optional parity via UART_RX_PARITY_EN) and the transmitter.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_SAMPLE = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } uart_state_e;

    // Clocks per oversample tick; truncating division matches the transmitter.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud_rate,
                                             input int unsigned oversample = OVERSAMPLE);
        return clk_freq / (oversample * baud_rate);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side UART link: serial input plus the parallel character outputs.
// parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if #(
    parameter int unsigned N = 8
);
    logic         rx;
    logic [N-1:0] d_in;
    logic         valid;
    logic         frame_err;
    logic         busy;
`ifdef UART_RX_PARITY_EN
    logic         parity_err;

    modport master (output rx, input d_in, input valid, input frame_err, input busy,
                    input parity_err);
    modport slave  (input rx, output d_in, output valid, output frame_err, output busy,
                    output parity_err);
`else
    modport master (output rx, input d_in, input valid, input frame_err, input busy);
    modport slave  (input rx, output d_in, output valid, output frame_err, output busy);
`endif
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-clk pulse every CLK_FREQ/(OVERSAMPLE*baud) clocks.
// Only rst clears the counter, so the tick phase is independent of line activity.
module uart_baud_tick #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned baud       = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int unsigned DIV  = uart_pkg::calc_div(CLK_FREQ, baud, OVERSAMPLE);
    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            wrap;

    always_comb begin
        wrap  = (cnt_q == CntW'(DIV - 1));
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = wrap;

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling 8N1 UART receiver with start-glitch rejection, framing check and break hold.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned N        = 8,
    parameter int unsigned baud     = 9600,
    parameter int unsigned CLK_FREQ = 100_000_000
) (
    input logic      clk,
    input logic      rst,
    uart_rx_if.slave bus
);
    localparam int unsigned BitW = $clog2(N);

    logic rx_meta_q, rxs_q;
    logic tick, mid_bit, end_bit;

    uart_state_e     state_q, state_d;
    logic [3:0]      sample_q, sample_d;
    logic [BitW-1:0] bit_q, bit_d;
    logic [N-1:0]    shift_q, shift_d;
    logic [N-1:0]    d_in_q, d_in_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            busy;
`ifdef UART_RX_PARITY_EN
    logic            perr_q, perr_d;
    logic            par_bad_q, par_bad_d;
`endif

    // rx is asynchronous to clk; idle-high reset values avoid a false start after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rxs_q     <= rx_meta_q;
        end
    end

    uart_baud_tick #(
        .CLK_FREQ  (CLK_FREQ),
        .baud      (baud),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_baud_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    assign mid_bit = tick && (sample_q == 4'(MID_SAMPLE - 1));
    assign end_bit = tick && (sample_q == 4'(OVERSAMPLE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (!rxs_q) state_d = START;
            START: if (mid_bit) state_d = rxs_q ? IDLE : DATA;
            DATA: begin
                if (end_bit && (bit_q == BitW'(N - 1))) begin
`ifdef UART_RX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (end_bit) state_d = STOP;
`endif
            // Leaving STOP mid-bit leaves half a bit to catch a back-to-back start edge.
            STOP:  if (end_bit) state_d = rxs_q ? IDLE : BREAK;
            BREAK: if (rxs_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sample_d = sample_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        d_in_d   = d_in_q;
        valid_d  = 1'b0;
        ferr_d   = 1'b0;
        busy     = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
        perr_d    = 1'b0;
        par_bad_d = par_bad_q;
`endif
        case (state_q)
            IDLE: begin
                sample_d = '0;
                bit_d    = '0;
            end
            START: begin
                bit_d = '0;
                if (tick) sample_d = mid_bit ? 4'd0 : sample_q + 4'd1;
            end
            DATA: begin
                if (tick) sample_d = sample_q + 4'd1;
                if (end_bit) begin
                    shift_d = {rxs_q, shift_q[N-1:1]};
                    bit_d   = bit_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) sample_d = sample_q + 4'd1;
                if (end_bit) par_bad_d = rxs_q ^ (^shift_q);
            end
`endif
            STOP: begin
                if (tick) sample_d = sample_q + 4'd1;
                if (end_bit) begin
                    if (!rxs_q) begin
                        ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad_q) begin
                        perr_d = 1'b1;
`endif
                    end else begin
                        valid_d = 1'b1;
                        d_in_d  = shift_q;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_q  <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            d_in_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
            par_bad_q <= 1'b0;
`endif
        end else begin
            sample_q  <= sample_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            d_in_q    <= d_in_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            perr_q    <= perr_d;
            par_bad_q <= par_bad_d;
`endif
        end
    end

    assign bus.d_in      = d_in_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = busy;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames against a frame-level event model (kind, data, time window).
// Runs a scaled clock/baud (64 clks per bit); honours UART_RX_PARITY_EN.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int unsigned N        = 8;
    localparam int unsigned BAUD     = 100_000;
    localparam int unsigned CLK_FREQ = 6_400_000;
    localparam int          BIT_CLKS = 64;
`ifdef UART_RX_PARITY_EN
    localparam int          LAT      = 672;  // 10.5 bits
`else
    localparam int          LAT      = 608;  // 9.5 bits
`endif

    typedef struct {
        int           kind;  // 0 valid, 1 frame_err, 2 parity_err
        logic [N-1:0] data;
        int           lo;
        int           hi;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    int           cyc = 0;
    int           vectors = 0;
    int           miscompares = 0;
    exp_t         exp_q[$];
    logic [N-1:0] model_d;
    logic         perr;

    uart_rx_if #(.N(N)) bus ();

    uart_rx #(
        .N       (N),
        .baud    (BAUD),
        .CLK_FREQ(CLK_FREQ)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

`ifdef UART_RX_PARITY_EN
    assign perr = bus.parity_err;
`else
    assign perr = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Compare process: every pulse must match the next expected frame event.
    always @(negedge clk) begin
        exp_t e;
        int   kind;
        if (rst) begin
            check("reset_outputs", {bus.valid, bus.frame_err, perr, bus.busy}, 4'b0);
        end else begin
            check("valid_and_ferr", {31'b0, bus.valid & bus.frame_err}, 0);
            if (bus.valid || bus.frame_err || perr) begin
                kind = bus.valid ? 0 : (bus.frame_err ? 1 : 2);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", kind, 32'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", kind, e.kind);
                    vectors++;
                    if (cyc < e.lo || cyc > e.hi) begin
                        miscompares++;
                        $display("FAIL pulse_time: got cycle %0d, expected %0d..%0d",
                                 cyc, e.lo, e.hi);
                    end
                    if (e.kind == 0) model_d = e.data;
                end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].hi) begin
                e = exp_q.pop_front();
                check("missing_pulse", 32'hFFFF, e.kind);
            end
        end
        check("d_in", bus.d_in, model_d);
    end

    task automatic drive_bits(input logic [11:0] bits, input int nb);
        for (int i = 0; i < nb; i++) begin
            bus.rx = bits[i];
            if (i == 2) check("busy_mid_frame", bus.busy, 1);
            repeat (BIT_CLKS) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [N-1:0] data, input logic stop, input logic par_flip);
        logic [11:0] bits;
        exp_t        e;
        logic        par;
        par = (^data) ^ par_flip;
`ifdef UART_RX_PARITY_EN
        bits = {1'b0, stop, par, data, 1'b0};
`else
        bits = {2'b00, stop, data, 1'b0};
`endif
        e.kind = !stop ? 1 : (par_flip ? 2 : 0);
        e.data = data;
        e.lo   = cyc + LAT - 6;
        e.hi   = cyc + LAT + 10;
        exp_q.push_back(e);
`ifdef UART_RX_PARITY_EN
        drive_bits(bits, 11);
`else
        drive_bits(bits, 10);
`endif
    endtask

    task automatic idle_bits(input int n);
        bus.rx = 1'b1;
        repeat (n * BIT_CLKS) @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        bus.rx  = 1'b1;
        model_d = '0;
        repeat (5) @(posedge clk);
        #1;
        check("reset_d_in", bus.d_in, 8'h00);
        check("reset_busy", bus.busy, 0);
        rst = 1'b0;
        idle_bits(2);

        // Single good frame.
        send_frame(8'hA5, 1'b1, 1'b0);
        idle_bits(1);
        check("a5_d_in", bus.d_in, 8'hA5);
        check("a5_busy_after", bus.busy, 0);

        // Short low glitch must be rejected at the mid-start sample.
        bus.rx = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("glitch_busy", bus.busy, 1);
        repeat (8) @(posedge clk);
        #1;
        bus.rx = 1'b1;
        repeat (BIT_CLKS / 2) @(posedge clk);
        #1;
        check("glitch_busy_clear", bus.busy, 0);
        idle_bits(2);

        // Bad stop bit, then a held-low line: one frame_err only.
        send_frame(8'h3C, 1'b0, 1'b0);
        bus.rx = 1'b0;
        repeat (3 * BIT_CLKS) @(posedge clk);
        #1;
        check("break_busy", bus.busy, 1);
        idle_bits(2);
        check("ferr_d_in_kept", bus.d_in, 8'hA5);
        send_frame(8'h11, 1'b1, 1'b0);
        idle_bits(1);
        check("after_break_d_in", bus.d_in, 8'h11);

        // Back-to-back frames, no idle gap.
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h55, 1'b1, 1'b0);
        idle_bits(1);
        check("b2b_last", bus.d_in, 8'h55);

        // Reset during bit 4 of 0xC3 (start + bits 0..3 sent, then half of bit 4).
        drive_bits({3'b000, 8'hC3, 1'b0}, 5);
        bus.rx = 1'b0;
        repeat (BIT_CLKS / 2) @(posedge clk);
        #1;
        rst     = 1'b1;
        bus.rx  = 1'b1;
        model_d = '0;
        #1;
        check("midframe_reset_d_in", bus.d_in, 8'h00);
        check("midframe_reset_busy", bus.busy, 0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        idle_bits(2);
        send_frame(8'h7E, 1'b1, 1'b0);
        idle_bits(1);
        check("after_reset_d_in", bus.d_in, 8'h7E);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h81, 1'b1, 1'b0);
        idle_bits(1);
        check("parity_ok_d_in", bus.d_in, 8'h81);
        send_frame(8'h42, 1'b1, 1'b1);
        idle_bits(1);
        check("parity_bad_d_in", bus.d_in, 8'h81);
`endif

        idle_bits(2);
        check("events_outstanding", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver paired with the existing transmitter; the board-side link accepts 8N1 serial characters from the host.
- Oversamples the asynchronous rx line at 16x baud, validates the start and stop bits, and presents each received character as a parallel word with a one-cycle valid strobe.
- Feeds the decode/command path that drives the Morse encoder.

Parameters:
- N, 8, data bits per frame (LSB first); legal range 5..8
- baud, 9600, line rate in bits/s
- CLK_FREQ, 100_000_000, system clock frequency in Hz

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- rx  input  1  serial line, asynchronous to clk, idles high
- d_in  output  N  last received character, held until the next good frame
- valid  output  1  one-clk pulse, d_in updated this cycle
- frame_err  output  1  one-clk pulse, stop bit sampled low
- busy  output  1  high from start-bit detect until return to IDLE

Behaviour:
- Reset (async, rst=1): d_in=0, valid=0, frame_err=0, busy=0, state=IDLE, all counters=0, sync flops=1.
- Input sync: rx passes through two flops (reset value 1); all logic uses the synced bit rxs.
- Tick generator: DIV = CLK_FREQ/(16*baud) (integer, 651 at defaults). Counter 0..DIV-1; a tick is a one-clk pulse at wrap. Free-running; reset to 0 only by rst.
- Sample counter: 4-bit, counts ticks within a bit; bit counter: 0..N-1.
- IDLE: busy=0. When rxs=0, go to START with sample counter=0, busy=1.
- START: on the 8th tick (mid-bit), if rxs=0 go to DATA with sample counter=0 and bit counter=0. If rxs=1, treat as a glitch and return to IDLE with no output pulse.
- DATA: on every 16th tick, shift rxs into the MSB of the shift register (right shift, LSB first). After bit N-1, go to STOP (or PARITY with the option).
- STOP: on the 16th tick, sample rxs.
  - rxs=1: d_in<=shift register, valid=1 for exactly one clk, go to IDLE.
  - rxs=0: frame_err=1 for one clk, d_in unchanged, no valid; go to BREAK.
- BREAK: stay until rxs=1, then go to IDLE. A held-low line yields exactly one frame_err.
- Latency: valid asserts 9.5 bit periods (8N1) after the start-bit falling edge, plus up to 1 tick of phase error plus 2 clks of sync delay.
- Back-to-back frames: IDLE is re-entered mid-stop-bit, so a start edge immediately after the stop bit is caught.
- valid and frame_err are never high in the same cycle.
- There is no ready/backpressure; the consumer must take d_in within one frame time. d_in stays stable between valid pulses.
- Reset mid-frame aborts at once with no pulses; reception resumes on the next falling edge after release.
- State encoding uses 3 bits; illegal codes go to IDLE.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA and samples one even-parity bit at its 16th tick.
  - Adds output parity_err (1 bit, reset 0).
  - If the parity bit mismatches and the stop bit is good: parity_err pulses one clk, no valid, d_in unchanged.
  - A bad stop bit gives frame_err only.
  - Latency becomes 10.5 bit periods.
- Undefined: there is no PARITY state and no parity_err port; behaviour is 8N1 as above.

Decomposition:
- Package uart_pkg:
  - State localparams IDLE/START/DATA/PARITY/STOP/BREAK.
  - OVERSAMPLE=16 and MID_SAMPLE=8.
  - A function computing DIV from CLK_FREQ and baud, shared with the transmitter.
- Sub-module uart_baud_tick (parameters CLK_FREQ, baud, OVERSAMPLE; ports clk, rst, tick): the free-running 16x tick generator.

Test Plan:
- Send 0xA5 8N1 at 9600 (bit = 10416 clks) → one valid pulse, d_in=0xA5, frame_err never high, busy low after stop.
- Low glitch of 3000 clks on idle rx → no valid, no frame_err, state back to IDLE, busy=0 within 5208 clks.
- Send 0x3C with stop bit forced 0, then hold rx low for 3 bit times → exactly one frame_err pulse, d_in keeps the prior value, next 0x11 frame received correctly.
- Back-to-back 0x00, 0xFF, 0x55 with no idle gap → three valid pulses carrying those values in order.
- Assert rst for 10 clks during bit 4 of 0xC3 → all outputs 0 immediately, no pulses; following 0x7E received as 0x7E.
- With UART_RX_PARITY_EN: 0x81 with correct even parity (0) → valid; with parity bit 1 → parity_err pulse, no valid.
